// File: rtl/tx_pkg.sv
// Shared types and constants for the BFSK frame transmitter.
// Build option: define TX_PARITY_EN to append an even-parity bit to each frame.
package tx_pkg;

  // Frame sequencer states; PARITY only exists when the parity bit is built in.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
`ifdef TX_PARITY_EN
    ,
    PARITY   = 2'd3
`endif
  } tx_state_t;

  localparam logic [7:0] TX_PREAMBLE     = 8'hAA;
  localparam int         TX_PREAMBLE_LEN = 8;
  localparam int         TX_DATA_LEN     = 8;

  // Bit 'idx' of a byte counted from the MSB (idx 0 selects bit 7).
  function automatic logic msb_first_bit(input logic [7:0] value, input logic [2:0] idx);
    return value[3'd7 - idx];
  endfunction

endpackage

// File: rtl/tx_nco.sv
// Phase-accumulator NCO producing a binary-FSK square wave from the phase MSB.
// The accumulator only clears on request, so switching frequency is phase-continuous.
module tx_nco #(
  parameter int                 PHASE_W = 16,
  parameter logic [PHASE_W-1:0] FREQ0   = PHASE_W'('h1000),
  parameter logic [PHASE_W-1:0] FREQ1   = PHASE_W'('h2000)
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  input  logic freq_sel,
  output logic carrier
);

  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;

  // Next phase: clear wins, otherwise advance by the selected increment (wraps mod 2^PHASE_W).
  always_comb begin
    phase_next = phase_reg;
    if (clear) begin
      phase_next = '0;
    end else if (enable) begin
      phase_next = phase_reg + (freq_sel ? FREQ1 : FREQ0);
    end
  end

  // Phase accumulator register.
  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign carrier = phase_reg[PHASE_W-1];

endmodule

// File: rtl/bfsk_frame_transmitter.sv
// Byte-in BFSK frame transmitter: preamble 8'hAA, then the data byte, MSB first,
// each bit held BIT_CYCLES clocks on a phase-continuous FSK carrier.
// Build option: define TX_PARITY_EN to add an even-parity bit after the data byte.
module bfsk_frame_transmitter
  import tx_pkg::*;
#(
  parameter int                 BIT_CYCLES = 16,
  parameter int                 PHASE_W    = 16,
  parameter logic [PHASE_W-1:0] FREQ0      = PHASE_W'('h1000),
  parameter logic [PHASE_W-1:0] FREQ1      = PHASE_W'('h2000)
) (
  input  logic       transmitter_clk,
  input  logic       transmitter_rst,
  input  logic [7:0] data_i,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_carrier,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       frame_done
);

  localparam int              CNT_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]      PRE_LAST  = 3'(TX_PREAMBLE_LEN - 1);
  localparam logic [2:0]      DATA_LAST = 3'(TX_DATA_LEN - 1);

  tx_state_t        state_reg, state_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [7:0]       data_reg, data_next;
  logic             tx_bit_reg, tx_bit_next;
  logic             tx_active_reg, tx_active_next;
  logic             frame_done_reg, frame_done_next;
  logic             handshake;
  logic             bit_last;

  assign data_ready = (state_reg == IDLE) && !transmitter_rst;
  assign handshake  = data_valid && data_ready;
  assign bit_last   = (cyc_cnt_reg == CNT_LAST);

`ifdef TX_PARITY_EN
  // Even parity of the latched byte as an XOR chain.
  logic [8:0] parity_chain;
  logic       parity_bit;
  assign parity_chain[0] = 1'b0;
  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    assign parity_chain[gi+1] = parity_chain[gi] ^ data_reg[gi];
  end
  assign parity_bit = parity_chain[8];
`endif

  // Sequencer: handshake in IDLE, then walk preamble/data(/parity) bits, one per BIT_CYCLES clocks.
  always_comb begin
    state_next      = state_reg;
    bit_idx_next    = bit_idx_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    data_next       = data_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          data_next    = data_i;
          bit_idx_next = '0;
          cyc_cnt_next = '0;
          state_next   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bit_last) begin
          cyc_cnt_next = '0;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == PRE_LAST) begin
            bit_idx_next = '0;
            state_next   = DATA;
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cyc_cnt_next = '0;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
`ifdef TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next      = IDLE;
            frame_done_next = 1'b1;
`endif
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          cyc_cnt_next    = '0;
          bit_idx_next    = '0;
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line bit for the coming cycle, taken from where the sequencer will be next.
  always_comb begin
    tx_bit_next    = 1'b0;
    tx_active_next = (state_next != IDLE);
    case (state_next)
      PREAMBLE: tx_bit_next = msb_first_bit(TX_PREAMBLE, bit_idx_next);
      DATA:     tx_bit_next = msb_first_bit(data_next, bit_idx_next);
`ifdef TX_PARITY_EN
      PARITY:   tx_bit_next = parity_bit;
`endif
      default:  tx_bit_next = 1'b0;
    endcase
  end

  // State, counters, byte latch and registered outputs.
  always_ff @(posedge transmitter_clk) begin
    if (transmitter_rst) begin
      state_reg      <= IDLE;
      bit_idx_reg    <= '0;
      cyc_cnt_reg    <= '0;
      data_reg       <= '0;
      tx_bit_reg     <= 1'b0;
      tx_active_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_idx_reg    <= bit_idx_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      data_reg       <= data_next;
      tx_bit_reg     <= tx_bit_next;
      tx_active_reg  <= tx_active_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Phase is held at zero while idle and restarts from zero on every frame;
  // the increment follows the bit currently on the line.
  tx_nco #(
    .PHASE_W (PHASE_W),
    .FREQ0   (FREQ0),
    .FREQ1   (FREQ1)
  ) u_nco (
    .clk      (transmitter_clk),
    .srst     (transmitter_rst),
    .clear    ((state_reg == IDLE) || (state_next == IDLE)),
    .enable   (state_reg != IDLE),
    .freq_sel (tx_bit_reg),
    .carrier  (tx_carrier)
  );

  assign tx_bit     = tx_bit_reg;
  assign tx_active  = tx_active_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bfsk_frame_transmitter.sv
// Self-checking bench for bfsk_frame_transmitter: a BIT_CYCLES=4 instance for framing,
// handshake and reset behaviour, and a default-parameter instance for carrier periods.
module tb_bfsk_frame_transmitter;

  localparam int BC  = 4;
  localparam int DBC = 16;
`ifdef TX_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif
  localparam logic [15:0] F0 = 16'h1000;
  localparam logic [15:0] F1 = 16'h2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       data_valid;
  logic       data_ready, tx_carrier, tx_bit, tx_active, frame_done;
  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready, d_carrier, d_bit, d_active, d_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bfsk_frame_transmitter #(.BIT_CYCLES(BC)) dut (
    .transmitter_clk (clk),
    .transmitter_rst (rst),
    .data_i          (data_i),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .tx_carrier      (tx_carrier),
    .tx_bit          (tx_bit),
    .tx_active       (tx_active),
    .frame_done      (frame_done)
  );

  bfsk_frame_transmitter dut_d (
    .transmitter_clk (clk),
    .transmitter_rst (rst),
    .data_i          (d_data),
    .data_valid      (d_valid),
    .data_ready      (d_ready),
    .tx_carrier      (d_carrier),
    .tx_bit          (d_bit),
    .tx_active       (d_active),
    .frame_done      (d_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame bit k: preamble AA, then the byte, then even parity.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    logic [7:0] pre;
    pre = 8'hAA;
    if (k < 8)       return pre[7-k];
    else if (k < 16) return b[15-k];
    else             return ^b;
  endfunction

  // Offer byte b (handshake at the next edge) and check the whole frame cycle by cycle.
  // abort_c >= 0 pulses reset after that frame cycle instead of finishing the frame.
  task automatic run_frame(input logic [7:0] b, input bit hold, input int abort_c);
    logic [15:0] ph;
    logic        eb;
    data_i     = b;
    data_valid = 1'b1;
    chk("ready_before", data_ready, 1);
    @(negedge clk);
    ph = '0;
    for (int c = 0; c < NBITS*BC; c++) begin
      if (hold) data_i = 8'($urandom);
      else      data_valid = 1'b0;
      eb = exp_bit(b, c / BC);
      chk("tx_active", tx_active, 1);
      chk("tx_bit", tx_bit, eb);
      chk("tx_carrier", tx_carrier, ph[15]);
      chk("frame_done_low", frame_done, 0);
      chk("ready_busy", data_ready, 0);
      if (c % BC == 0) chk("phase_cont", dut.u_nco.phase_reg, ph);
      ph = ph + (eb ? F1 : F0);
      if (c == abort_c) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_active", tx_active, 0);
        chk("abort_carrier", tx_carrier, 0);
        chk("abort_bit", tx_bit, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_ready_rst", data_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_ready", data_ready, 1);
        chk("abort_idle_done", frame_done, 0);
        chk("abort_idle_active", tx_active, 0);
        $display("frame byte=%02h aborted by reset after cycle %0d", b, c);
        return;
      end
      @(negedge clk);
    end
    chk("frame_done", frame_done, 1);
    chk("active_end", tx_active, 0);
    chk("ready_end", data_ready, 1);
    chk("carrier_end", tx_carrier, 0);
    chk("bit_end", tx_bit, 0);
    $display("frame byte=%02h bits=%0d hold=%0d done", b, NBITS, hold);
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", frame_done, 0);
      chk("idle_active", tx_active, 0);
      chk("idle_ready", data_ready, 1);
      chk("idle_carrier", tx_carrier, 0);
    end
  endtask

  // Default-parameter frame of 8'h0F: check carrier against phase arithmetic and
  // measure rising-edge spacing inside runs of equal bits.
  task automatic run_default();
    logic [15:0] ph;
    logic        eb, prev_bit, prev_car;
    int          last_rise, last_change;
    d_data  = 8'h0F;
    d_valid = 1'b1;
    chk("d_ready_before", d_ready, 1);
    @(negedge clk);
    d_valid     = 1'b0;
    ph          = '0;
    prev_car    = 1'b0;
    prev_bit    = 1'b1;
    last_rise   = -1;
    last_change = 0;
    for (int c = 0; c < NBITS*DBC; c++) begin
      eb = exp_bit(8'h0F, c / DBC);
      chk("d_tx_bit", d_bit, eb);
      chk("d_carrier", d_carrier, ph[15]);
      chk("d_active", d_active, 1);
      if (c > 0 && eb != prev_bit) last_change = c;
      if (d_carrier && !prev_car) begin
        if (last_rise > last_change) chk("carrier_period", c - last_rise, eb ? 8 : 16);
        last_rise = c;
      end
      prev_car = d_carrier;
      prev_bit = eb;
      ph = ph + (eb ? F1 : F0);
      @(negedge clk);
    end
    chk("d_frame_done", d_done, 1);
    chk("d_active_end", d_active, 0);
    chk("d_ready_end", d_ready, 1);
    $display("default frame byte=0f bits=%0d done", NBITS);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    data_i     = '0;
    data_valid = 1'b0;
    d_data     = '0;
    d_valid    = 1'b0;
    @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", data_ready, 0);
      chk("rst_carrier", tx_carrier, 0);
      chk("rst_bit", tx_bit, 0);
      chk("rst_active", tx_active, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_d_ready", d_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", data_ready, 1);
    chk("post_rst_active", tx_active, 0);
    chk("post_rst_done", frame_done, 0);
    $display("reset released");

    run_frame(8'hE8, 1'b0, -1);
    idle(3);
    run_frame(8'h01, 1'b0, -1);
    idle(2);

    // valid held high with changing data; the next byte goes 1 clock after frame_done
    run_frame(8'($urandom), 1'b1, -1);
    run_frame(8'h5A, 1'b0, -1);
    idle(2);

    // reset during data bit 5 (frame bit 13), then a clean frame
    run_frame(8'($urandom), 1'b0, 13*BC + 1);
    run_frame(8'h3C, 1'b0, -1);
    idle(2);

    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), bit'($urandom_range(0, 1)), -1);
      idle($urandom_range(1, 4));
    end

    run_default();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
